pipelined_adder: RTL and testbench

- Parametrised successor to the single-bit full adder: a WIDTH-bit add/subtract unit with the carry chain split across STAGES pipeline registers.
- Intended as the ALU adder path in the 32-bit MIPS pipeline and as a reusable arithmetic block.
- Valid/ready handshake on both sides with full backpressure.
- Produces sum, carry-out, signed overflow and zero flags.

---
 rtl/pipelined_adder_pkg.sv | 15 +
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/pipelined_adder_stage.sv | 65 ++++++
 rtl/pipelined_adder.sv | 74 +++++++
 tb/tb_pipelined_adder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// chunk_w : bits resolved per pipeline stage (WIDTH/STAGES).
// geom_ok : legal geometry, i.e. 1 <= STAGES <= WIDTH and STAGES divides WIDTH.
package pipelined_adder_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(int width, int stages);
    return width / stages;
  endfunction

  function automatic bit geom_ok(int width, int stages);
    return (stages >= 1) && (stages <= width) && (width % stages == 0);
  endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Input side : in_valid/in_ready, a, b, ci, sub.
// Output side: out_valid/out_ready, s, co, ovf, zero.
// master = operand source / result sink, slave = the adder.
interface pipelined_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/pipelined_adder_stage.sv
// One pipeline slice of the adder: ripple-adds chunk IDX of a/bx plus the
// incoming carry, and registers the whole skewed word alongside it.
// Ports:
//   clk, rst        clock, async active-high reset
//   in_vld/in_rdy   upstream handshake (in_rdy = this slice can load)
//   in_a/in_bx      full operands (chunks above IDX still unresolved)
//   in_s            sum with chunks below IDX already resolved
//   in_c            carry into chunk IDX
//   out_vld/out_rdy downstream handshake
//   out_a/out_bx/out_s/out_c registered copies for the next slice
module adder_stage #(
  parameter int CHUNK = 8,
  parameter int WIDTH = 32,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_bx,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_c,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_bx,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c
);
  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   add_w;
  logic [WIDTH-1:0] s_nxt;

  assign add_w = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_bx[LO +: CHUNK]}
               + (CHUNK+1)'(in_c);

  always_comb begin
    s_nxt               = in_s;
    s_nxt[LO +: CHUNK]  = add_w[CHUNK-1:0];
  end

  // Load when empty or when the slice downstream drains us this cycle.
  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_a   <= '0;
      out_bx  <= '0;
      out_s   <= '0;
      out_c   <= 1'b0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      // Payload only moves with a real beat so a drained slice keeps its data.
      if (in_vld) begin
        out_a  <= in_a;
        out_bx <= in_bx;
        out_s  <= s_nxt;
        out_c  <= add_w[CHUNK];
      end
    end
  end
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit with the carry chain split over STAGES slices.
// Result = a + (sub ? ~b : b) + (sub ? ~ci : ci); latency STAGES, 1 beat/cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (drops all in-flight beats)
//   bus  slave side of pipelined_adder_if (operands in, s/co/ovf/zero out)
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_adder_if.slave   bus
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!geom_ok(WIDTH, STAGES)) begin : g_bad_geom
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  // Index k is the input of slice k; index STAGES is the output register.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy_pipe;
  logic [STAGES:0]            c_pipe;
  logic [STAGES:0][WIDTH-1:0] a_pipe;
  logic [STAGES:0][WIDTH-1:0] bx_pipe;
  logic [STAGES:0][WIDTH-1:0] s_pipe;
  logic                       c_into_msb;
  logic                       unused_skew;

  assign vld_pipe[0] = bus.in_valid;
  assign a_pipe[0]   = bus.a;
  assign bx_pipe[0]  = bus.sub ? ~bus.b : bus.b;
  assign c_pipe[0]   = bus.sub ? ~bus.ci : bus.ci;
  assign s_pipe[0]   = '0;
  assign rdy_pipe[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(.CHUNK(CHUNK), .WIDTH(WIDTH), .IDX(k)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (vld_pipe[k]),
      .in_rdy  (rdy_pipe[k]),
      .in_a    (a_pipe[k]),
      .in_bx   (bx_pipe[k]),
      .in_s    (s_pipe[k]),
      .in_c    (c_pipe[k]),
      .out_vld (vld_pipe[k+1]),
      .out_rdy (rdy_pipe[k+1]),
      .out_a   (a_pipe[k+1]),
      .out_bx  (bx_pipe[k+1]),
      .out_s   (s_pipe[k+1]),
      .out_c   (c_pipe[k+1])
    );
  end

  // Nothing is accepted while reset is held.
  assign bus.in_ready = rdy_pipe[0] & ~rst;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ bx ^ cin.
  assign c_into_msb = a_pipe[STAGES][WIDTH-1] ^ bx_pipe[STAGES][WIDTH-1]
                    ^ s_pipe[STAGES][WIDTH-1];
  // Rest of the last slice's operand copies have no consumer.
  assign unused_skew = ^{a_pipe[STAGES], bx_pipe[STAGES]};

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.s         = s_pipe[STAGES];
  assign bus.co        = c_pipe[STAGES];
  assign bus.ovf       = c_pipe[STAGES] ^ c_into_msb;
  // Qualified by valid so the cleared register does not report zero.
  assign bus.zero      = vld_pipe[STAGES] & ~|s_pipe[STAGES];
endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    res_t        r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a_r = '0, b_r = '0;
  logic ci_r = 1'b0, sub_r = 1'b0, iv_r = 1'b0, or_r = 1'b1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int n_out  = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) if4 ();
  pipelined_adder_if #(.WIDTH(32)) if1 ();
  pipelined_adder_if #(.WIDTH(32)) if32 ();

  assign if4.in_valid = iv_r;   assign if1.in_valid = iv_r;   assign if32.in_valid = iv_r;
  assign if4.a = a_r;           assign if1.a = a_r;           assign if32.a = a_r;
  assign if4.b = b_r;           assign if1.b = b_r;           assign if32.b = b_r;
  assign if4.ci = ci_r;         assign if1.ci = ci_r;         assign if32.ci = ci_r;
  assign if4.sub = sub_r;       assign if1.sub = sub_r;       assign if32.sub = sub_r;
  assign if4.out_ready = or_r;  assign if1.out_ready = or_r;  assign if32.out_ready = or_r;

  pipelined_adder #(.WIDTH(32), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  pipelined_adder #(.WIDTH(32), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  pipelined_adder #(.WIDTH(32), .STAGES(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a-b-ci / a+b+ci.
  function automatic res_t model(logic [31:0] a, logic [31:0] b, logic ci, logic sub);
    res_t r;
    longint ua, ub, sa, sb, u, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      u  = ua + ub + longint'(ci);
      sr = sa + sb + longint'(ci);
      r.co = (u >= 64'sd4294967296);
    end else begin
      u  = ua - ub - longint'(ci);
      sr = sa - sb - longint'(ci);
      r.co = (u >= 0);
    end
    r.s    = u[31:0];
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  // Scoreboard on the STAGES=4 instance; sampled mid-cycle.
  bit          hold_prev = 1'b0;
  logic [31:0] prev_s = '0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (if4.in_valid && if4.in_ready)
        exp_q.push_back(model(if4.a, if4.b, if4.ci, if4.sub));
      if (hold_prev)
        chk("hold_s", {31'd0, if4.out_valid, if4.s}, {31'd0, 1'b1, prev_s});
      if (if4.out_valid && if4.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb_result", 64'({if4.s, if4.co, if4.ovf, if4.zero}), 64'(e));
        end
      end
      hold_prev = if4.out_valid && !if4.out_ready;
      prev_s    = if4.s;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];

  initial begin
    int lat4, lat1, lat32, acc, i, n0, vcnt, lat;
    bit hs, drop_seen;
    res_t r4, r1, r32;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    tbl[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{32'h12345678, 32'h00000000, 1'b1, 1'b0, '{32'h12345679, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
    tbl[7] = '{32'h00000009, 32'h00000009, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};

    // 1. reset
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_held_valid", 64'(if4.out_valid), 64'd0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_out_valid", 64'({if4.out_valid, if1.out_valid, if32.out_valid}), 64'd0);
    chk("rst_in_ready", 64'({if4.in_ready, if1.in_ready, if32.in_ready}), 64'b111);
    chk("rst_outputs", 64'({if4.s, if4.co, if4.ovf, if4.zero}), 64'd0);
    tick();

    // 2/3. vector table on all three depths, with latency
    for (int v = 0; v < 8; v++) begin
      a_r = tbl[v].a; b_r = tbl[v].b; ci_r = tbl[v].ci; sub_r = tbl[v].sub;
      iv_r = 1'b1; or_r = 1'b1;
      @(negedge clk);
      chk("tbl_in_ready", 64'({if4.in_ready, if1.in_ready, if32.in_ready}), 64'b111);
      tick();
      iv_r = 1'b0;
      lat4 = 0; lat1 = 0; lat32 = 0;
      r4 = '0; r1 = '0; r32 = '0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (if4.out_valid && lat4 == 0) begin lat4 = c; r4 = {if4.s, if4.co, if4.ovf, if4.zero}; end
        if (if1.out_valid && lat1 == 0) begin lat1 = c; r1 = {if1.s, if1.co, if1.ovf, if1.zero}; end
        if (if32.out_valid && lat32 == 0) begin lat32 = c; r32 = {if32.s, if32.co, if32.ovf, if32.zero}; end
      end
      chk($sformatf("tbl%0d_lat4", v), 64'(lat4), 64'd4);
      chk($sformatf("tbl%0d_lat1", v), 64'(lat1), 64'd1);
      chk($sformatf("tbl%0d_lat32", v), 64'(lat32), 64'd32);
      chk($sformatf("tbl%0d_res4", v), 64'(r4), 64'(tbl[v].r));
      chk($sformatf("tbl%0d_res1", v), 64'(r1), 64'(tbl[v].r));
      chk($sformatf("tbl%0d_res32", v), 64'(r32), 64'(tbl[v].r));
      tick();
    end

    // 1b. asynchronous reset between edges
    a_r = 32'd3; b_r = 32'd4; ci_r = 1'b0; sub_r = 1'b0;
    or_r = 1'b0; iv_r = 1'b1;
    tick();
    iv_r = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("async_pre_valid", 64'({if4.out_valid, if4.s}), 64'({1'b1, 32'd7}));
    #2 rst = 1'b1;
    #1 chk("async_drop_valid", 64'({if4.out_valid, if1.out_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    or_r = 1'b1;
    tick();

    // 4. stall with out_ready low for the first 6 cycles
    mon_en = 1'b1;
    n0 = n_out; acc = 0; i = 1; drop_seen = 1'b0;
    for (int cyc = 0; cyc < 80 && (i <= 8 || exp_q.size() > 0); cyc++) begin
      or_r = (cyc >= 6);
      iv_r = (i <= 8);
      a_r = 32'(i); b_r = 32'(i); ci_r = i[0]; sub_r = 1'b0;
      @(negedge clk);
      hs = iv_r && if4.in_ready;
      if (hs) acc++;
      if (iv_r && !if4.in_ready && !drop_seen) begin
        drop_seen = 1'b1;
        chk("stall_accepts", 64'(acc), 64'd4);
      end
      tick();
      if (hs) i++;
    end
    iv_r = 1'b0; or_r = 1'b1;
    chk("stall_drop_seen", 64'(drop_seen), 64'd1);
    chk("stall_count", 64'(n_out - n0), 64'd8);
    chk("stall_q_empty", 64'(exp_q.size()), 64'd0);

    // 5. random operands, out_ready toggling each cycle
    n0 = n_out; acc = 0;
    a_r = $urandom; b_r = $urandom; ci_r = 1'($urandom_range(0, 1)); sub_r = 1'($urandom_range(0, 1));
    iv_r = 1'b1; or_r = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      hs = if4.in_ready;
      tick();
      if (hs) begin
        acc++;
        a_r = $urandom; b_r = $urandom;
        ci_r = 1'($urandom_range(0, 1)); sub_r = 1'($urandom_range(0, 1));
      end
      or_r = ~or_r;
    end
    iv_r = 1'b0; or_r = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) tick();
    tick();
    chk("rand_q_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_count", 64'(n_out - n0), 64'(acc));

    // 6. reset with 3 beats in flight
    or_r = 1'b0; iv_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_r = 32'(100 + k); b_r = 32'd1; ci_r = 1'b0; sub_r = 1'b0;
      tick();
    end
    iv_r = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid", 64'({if4.out_valid, if4.in_ready}), 64'd0);
    rst = 1'b0;
    tick();
    or_r = 1'b1;
    a_r = 32'h00000010; b_r = 32'h00000003; ci_r = 1'b1; sub_r = 1'b1;
    iv_r = 1'b1;
    tick();
    iv_r = 1'b0;
    vcnt = 0; lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (if4.out_valid) begin
        vcnt++;
        if (lat == 0) begin
          lat = c;
          chk("flush_new_s", 64'(if4.s), 64'h0000000C);
        end
      end
    end
    chk("flush_lat", 64'(lat), 64'd4);
    chk("flush_alone", 64'(vcnt), 64'd1);
    chk("flush_q_empty", 64'(exp_q.size()), 64'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
